audio_i2s_tx: RTL and testbench

Parametrised I2S audio transmitter that drives the on-board DAC/headphone path (hp_bck/hp_ws/hp_din) from the core's signed audio outputs. It generalises the fixed-rate, mono-only audio logic in the video/output top level. It adds a runtime bit-clock divider, true stereo or mono-mix mode, configurable input, output and slot widths, saturating mix, and a per-frame sample request strobe. It sits in the output top level next to the scandoubler/OSD path, clocked by the video clock.

---
 rtl/audio_i2s_tx.sv | 173 +++++++++++++++++
 tb/tb_audio_i2s_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter for the DAC/headphone path.
// Three-stage sample pipeline (truncate, optional saturating mono mix, volume)
// feeds a frame hold register; a runtime divider generates bck, and each
// falling bck edge shifts one bit of the left-aligned slot word onto din.
module audio_i2s_tx #(
    parameter int IN_W         = 18,
    parameter int OUT_W        = 16,
    parameter int SLOT_W       = 16,
    parameter int DIV_W        = 9,
    parameter int UNSIGNED_OUT = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [DIV_W-1:0]        div,
    input  logic                    mono,
    input  logic [1:0]              volume,
    input  logic signed [IN_W-1:0]  audio_l,
    input  logic signed [IN_W-1:0]  audio_r,
    output logic                    sample_req,
    output logic                    bck,
    output logic                    ws,
    output logic                    din,
    output logic                    pa_en
);

    localparam int NUM_CH = 2;              // index 0 = left, 1 = right
    localparam int FRAME  = 2 * SLOT_W;
    localparam int BC_W   = $clog2(FRAME);
    localparam logic MSB_INV = (UNSIGNED_OUT != 0);

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // ---------------------------------------------------------------------
    // Sample pipeline
    // ---------------------------------------------------------------------
    logic [NUM_CH-1:0][IN_W-1:0]  audio_in;
    logic [NUM_CH-1:0][OUT_W-1:0] s1_d, s1_q;
    logic [NUM_CH-1:0][OUT_W-1:0] s2_q;
    logic [NUM_CH-1:0][OUT_W-1:0] s3_d, s3_q;
    logic [NUM_CH-1:0][OUT_W-1:0] hold_q;

    logic [OUT_W:0]   mix_sum;
    logic [OUT_W-1:0] mix_sat;

    assign audio_in = {audio_r, audio_l};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [OUT_W-1:0] scaled;

        // An arithmetic shift right by IN_W-OUT_W followed by truncation to
        // OUT_W bits is exactly the top OUT_W bits of the input.
        assign s1_d[c] = audio_in[c][IN_W-1 -: OUT_W];

        // Volume as an arithmetic attenuation; code 0 mutes
        always_comb begin
            scaled = '0;
            case (volume)
                2'd1:    scaled = $signed(s2_q[c]) >>> 2;
                2'd2:    scaled = $signed(s2_q[c]) >>> 1;
                2'd3:    scaled = $signed(s2_q[c]);
                default: scaled = '0;
            endcase
        end

        // Offset-binary builds flip the sign bit after muting, so mute maps
        // to the mid-scale code.
        assign s3_d[c] = {scaled[OUT_W-1] ^ MSB_INV, scaled[OUT_W-2:0]};
    end

    // Input LSBs below the transmitted word are intentionally discarded.
    logic unused_lsbs;
    assign unused_lsbs = ^audio_in;

    // Mono mix: one extra bit of headroom, then clamp on overflow
    always_comb begin
        mix_sum = {s1_q[0][OUT_W-1], s1_q[0]} + {s1_q[1][OUT_W-1], s1_q[1]};
        mix_sat = mix_sum[OUT_W-1:0];
        case (mix_sum[OUT_W -: 2])
            2'b01:   mix_sat = SAT_MAX;
            2'b10:   mix_sat = SAT_MIN;
            default: mix_sat = mix_sum[OUT_W-1:0];
        endcase
    end

    // Pipeline registers run every clk, independent of enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= mono ? {mix_sat, mix_sat} : s1_q;
            s3_q <= s3_d;
        end
    end

    // ---------------------------------------------------------------------
    // Serializer
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0]  cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [BC_W-1:0]   n_next;      // bit_cnt after the coming falling edge
    logic [BC_W-1:0]   n_after;     // one position further, drives ws lead
    logic [BC_W-1:0]   pos;         // position within the current slot
    logic              is_right;
    logic [OUT_W-1:0]  word;
    logic [SLOT_W-1:0] slot_word;
    logic [SLOT_W-1:0] slot_shift;
    logic              slot_bit;
    logic              ws_next;

    // Next bit selection; at frame start the fresh S3 left word is used
    // directly since the hold register is only loaded on that same edge.
    always_comb begin
        n_next     = (bit_cnt == BC_W'(FRAME-1)) ? '0 : bit_cnt + 1'b1;
        n_after    = (n_next  == BC_W'(FRAME-1)) ? '0 : n_next + 1'b1;
        is_right   = (n_next >= BC_W'(SLOT_W));
        pos        = is_right ? n_next - BC_W'(SLOT_W) : n_next;
        if (is_right)
            word = hold_q[1];
        else if (n_next == '0)
            word = s3_q[0];
        else
            word = hold_q[0];
        slot_word  = SLOT_W'(word) << (SLOT_W - OUT_W);
        slot_shift = slot_word << pos;
        slot_bit   = slot_shift[SLOT_W-1];
        ws_next    = (n_after >= BC_W'(SLOT_W));
    end

    // Divider, bit shifting and frame latch; disable parks at a clean frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            bit_cnt    <= BC_W'(FRAME-1);
            bck        <= 1'b0;
            ws         <= 1'b0;
            din        <= 1'b0;
            sample_req <= 1'b0;
            pa_en      <= 1'b0;
            hold_q     <= '0;
        end else begin
            sample_req <= 1'b0;
            pa_en      <= enable;
            if (!enable) begin
                cnt     <= '0;
                bit_cnt <= BC_W'(FRAME-1);
                bck     <= 1'b0;
                ws      <= 1'b0;
                din     <= 1'b0;
            end else if (cnt >= div) begin
                // >= rather than == so a lowered div cannot strand cnt above it
                cnt <= '0;
                bck <= ~bck;
                if (bck) begin
                    bit_cnt <= n_next;
                    din     <= slot_bit;
                    ws      <= ws_next;
                    if (n_next == '0) begin
                        hold_q     <= s3_q;
                        sample_req <= 1'b1;
                    end
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed vectors with a frame scoreboard. Stimulus pushes
// expected slot words; the monitor deserializes din on each falling bck edge
// from a sample_req frame start and compares against the queue head.
module tb_audio_i2s_tx;

    localparam int IN_W = 18, OUT_W = 16, SLOT_W = 16, DIV_W = 9;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic              mono = 1'b0;
    logic [1:0]        volume = 2'd3;
    logic [IN_W-1:0]   audio_l = '0;
    logic [IN_W-1:0]   audio_r = '0;
    logic sample_req, bck, ws, din, pa_en;
    logic sample_req_u, bck_u, ws_u, din_u, pa_en_u;

    always #5 clk = ~clk;

    audio_i2s_tx #(.IN_W(IN_W), .OUT_W(OUT_W), .SLOT_W(SLOT_W), .DIV_W(DIV_W),
                   .UNSIGNED_OUT(0)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .div(div), .mono(mono),
        .volume(volume), .audio_l(audio_l), .audio_r(audio_r),
        .sample_req(sample_req), .bck(bck), .ws(ws), .din(din), .pa_en(pa_en));

    audio_i2s_tx #(.IN_W(IN_W), .OUT_W(OUT_W), .SLOT_W(SLOT_W), .DIV_W(DIV_W),
                   .UNSIGNED_OUT(1)) dut_u (
        .clk(clk), .reset_n(reset_n), .enable(enable), .div(div), .mono(mono),
        .volume(volume), .audio_l(audio_l), .audio_r(audio_r),
        .sample_req(sample_req_u), .bck(bck_u), .ws(ws_u), .din(din_u), .pa_en(pa_en_u));

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;

    frame_t expq[$];
    string  nameq[$];
    int     n_chk = 0;
    int     n_pass = 0;
    bit     mon_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting", nm);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r, input string nm);
        frame_t f;
        f.l = l;
        f.r = r;
        expq.push_back(f);
        nameq.push_back(nm);
    endtask

    task automatic wait_sreq(input string nm);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!sample_req && k < 2000);
        if (!sample_req) timeout({nm, " sample_req"});
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while ((expq.size() != 0 || mon_busy) && k < 3000);
        if (expq.size() != 0 || mon_busy) timeout({nm, " frame"});
    endtask

    // Apply inputs, skip the frame already latched, then check the next one
    task automatic send(input logic [17:0] l, input logic [17:0] r, input logic m,
                        input logic [1:0] v, input logic [15:0] el, input logic [15:0] er,
                        input string nm);
        audio_l = l; audio_r = r; mono = m; volume = v;
        wait_sreq(nm);
        @(negedge clk);
        push(el, er, nm);
        wait_idle(nm);
    endtask

    task automatic sreq_interval(output int clks);
        clks = 0;
        wait_sreq("interval start");
        do begin @(negedge clk); clks++; end while (!sample_req && clks < 2000);
    endtask

    task automatic half_period(output int hp);
        logic prev;
        int   k;
        k = 0;
        do begin prev = bck; @(negedge clk); k++; end while (!(!prev && bck) && k < 1000);
        hp = 0;
        while (bck && hp < 1000) begin @(negedge clk); hp++; end
    endtask

    // Monitor: deserialize both DUT streams and score each requested frame
    initial begin : monitor
        logic        prev_bck;
        int          nb;
        int          ws_bad;
        logic [31:0] sh, shu;
        frame_t      e;
        string       nm;
        prev_bck = 1'b0; nb = 0; ws_bad = 0; sh = '0; shu = '0; nm = "";
        e.l = '0; e.r = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_bck = 1'b0;
                mon_busy = 1'b0;
            end else begin
                if (sample_req && !mon_busy && expq.size() > 0) begin
                    e = expq.pop_front();
                    nm = nameq.pop_front();
                    mon_busy = 1'b1;
                    nb = 0;
                    ws_bad = 0;
                end
                if (mon_busy && prev_bck && !bck) begin
                    sh  = {sh[30:0], din};
                    shu = {shu[30:0], din_u};
                    if (ws !== (((nb + 1) % 32) >= 16)) ws_bad++;
                    nb++;
                    if (nb == 32) begin
                        chk({nm, " left"},  {16'h0, sh[31:16]}, {16'h0, e.l});
                        chk({nm, " right"}, {16'h0, sh[15:0]},  {16'h0, e.r});
                        chk({nm, " left offset-binary"},  {16'h0, shu[31:16]}, {16'h0, e.l ^ 16'h8000});
                        chk({nm, " right offset-binary"}, {16'h0, shu[15:0]},  {16'h0, e.r ^ 16'h8000});
                        chk({nm, " ws errors"}, ws_bad, 0);
                        mon_busy = 1'b0;
                    end
                end
                prev_bck = bck;
            end
        end
    end

    // Stimulus
    initial begin : stim
        int bad, k, first, iv, hp, falls;
        logic prev;

        audio_l = 18'h3FFFC; audio_r = 18'h00004; volume = 2'd3; mono = 1'b0;
        div = '0; enable = 1'b0; reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {bck, ws, din, sample_req, pa_en}, 0);
        reset_n = 1'b1;

        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if ({bck, ws, din, sample_req, pa_en} !== 5'b0) bad++;
        end
        chk("idle outputs quiet", bad, 0);

        // Enable with div=0; first frame carries the settled stereo sample
        push(16'hFFFF, 16'h0001, "stereo -4/+4");
        enable = 1'b1;
        k = 0; first = 0;
        repeat (8) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("pa_en one clk after enable", pa_en, 1);
            if (sample_req && first == 0) first = k;
        end
        chk("first sample_req clk", first, 2);
        wait_idle("stereo -4/+4");
        sreq_interval(iv);
        chk("frame interval div0", iv, 64);

        send(18'h12345, 18'h2ABCD, 1'b0, 2'd3, 16'h48D1, 16'hAAF3, "stereo mixed");
        send(18'h1FFFF, 18'h1FFFF, 1'b1, 2'd3, 16'h7FFF, 16'h7FFF, "mono sat pos");
        send(18'h20000, 18'h20000, 1'b1, 2'd3, 16'h8000, 16'h8000, "mono sat neg");
        send(18'h00010, 18'h3FFF0, 1'b1, 2'd3, 16'h0000, 16'h0000, "mono cancel");
        send(18'h00100, 18'h00200, 1'b1, 2'd3, 16'h00C0, 16'h00C0, "mono sum");
        send(18'h1FFFF, 18'h1FFFF, 1'b0, 2'd2, 16'h3FFF, 16'h3FFF, "vol2");
        send(18'h1FFFF, 18'h1FFFF, 1'b0, 2'd1, 16'h1FFF, 16'h1FFF, "vol1");
        send(18'h1FFFF, 18'h1FFFF, 1'b0, 2'd0, 16'h0000, 16'h0000, "vol0 mute");
        send(18'h12345, 18'h2ABCD, 1'b0, 2'd2, 16'h2468, 16'hD579, "vol2 mixed");

        // Divider: slow down, then speed up in the middle of a checked frame
        div = 9'd3;
        wait_sreq("div3 settle");
        sreq_interval(iv);
        chk("frame interval div3", iv, 256);
        half_period(hp);
        chk("bck half period div3", hp, 4);
        wait_sreq("div change frame");
        @(negedge clk);
        audio_l = 18'h1FFFF; audio_r = 18'h3FFFC; mono = 1'b0; volume = 2'd3;
        push(16'h7FFF, 16'hFFFF, "div change frame");
        k = 0;
        while (!mon_busy && k < 2000) begin @(negedge clk); k++; end
        if (!mon_busy) timeout("div change capture");
        repeat (40) @(negedge clk);
        div = 9'd1;
        wait_idle("div change frame");
        half_period(hp);
        chk("bck half period div1", hp, 2);
        sreq_interval(iv);
        chk("frame interval div1", iv, 128);

        // Abort at n=20
        wait_sreq("abort frame");
        falls = 0; k = 0;
        while (falls < 20 && k < 500) begin
            prev = bck;
            @(negedge clk);
            k++;
            if (prev && !bck) falls++;
        end
        chk("reached n=20 before abort", falls, 20);
        chk("ws high at n=20", ws, 1);
        enable = 1'b0;
        audio_l = 18'h0ABCC; audio_r = 18'h35554;
        @(negedge clk);
        chk("outputs zero after abort", {bck, ws, din, sample_req, pa_en}, 0);
        bad = 0;
        repeat (50) begin @(negedge clk); if (sample_req) bad++; end
        chk("no sample_req while idle", bad, 0);

        // Re-enable: clean frame start with a fresh latch
        push(16'h2AF3, 16'hD555, "restart frame");
        enable = 1'b1;
        k = 0; first = 0;
        repeat (10) begin
            @(negedge clk);
            k++;
            if (sample_req && first == 0) first = k;
        end
        chk("first sample_req after re-enable", first, 4);
        wait_idle("restart frame");

        // Asynchronous reset between clock edges
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async reset outputs", {bck, ws, din, sample_req, pa_en}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("scoreboard drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
